// File: rtl/synapse_row_accumulator.sv
// synapse_row_accumulator
//
// Scans the NUM_NEURONS x NUM_NEURONS synapse weight matrix one row at a time.
// For each row it forms the signed coupling sum sum_j W[i][j]*s_j, where s_j is
// +1 or -1 according to a snapshot of the neuron phase vector. Each row result
// is handed to the phase-update logic through a valid/ready handshake.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   start         one-cycle scan request, only honoured while idle
//   neuron_state  phase bits (1 -> s=+1, 0 -> s=-1), captured on start
//   addr_row      registered row address to the weight memory
//   addr_col      registered column address to the weight memory
//   weight        signed W[addr_row][addr_col], combinational from memory
//   busy          high whenever a scan is in progress (any non-idle state)
//   sum_valid     a row result is being presented
//   sum_ready     consumer accepts the presented result
//   sum_row       neuron index of the presented result
//   sum_data      signed coupling sum for sum_row
//   sum_sign      next-phase bit, 1 when sum_data >= 0
//   done          one-cycle pulse after the last row has been accepted
module synapse_row_accumulator #(
  parameter int NUM_NEURONS  = 15,
  parameter int WEIGHT_WIDTH = 5,
  parameter int SUM_WIDTH    = 9,
  parameter int ADDR_WIDTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_NEURONS-1:0]        neuron_state,
  output logic [ADDR_WIDTH-1:0]         addr_row,
  output logic [ADDR_WIDTH-1:0]         addr_col,
  input  logic signed [WEIGHT_WIDTH-1:0] weight,
  output logic                          busy,
  output logic                          sum_valid,
  input  logic                          sum_ready,
  output logic [ADDR_WIDTH-1:0]         sum_row,
  output logic signed [SUM_WIDTH-1:0]   sum_data,
  output logic                          sum_sign,
  output logic                          done
);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_NEURONS - 1);

  state_t                        state_reg, state_next;
  logic [NUM_NEURONS-1:0]        snap_reg;
  logic [ADDR_WIDTH-1:0]         row_reg, col_reg;
  logic signed [SUM_WIDTH-1:0]   acc_reg;
  logic                          sum_valid_reg;
  logic [ADDR_WIDTH-1:0]         sum_row_reg;
  logic signed [SUM_WIDTH-1:0]   sum_data_reg;
  logic                          sum_sign_reg;

  logic                          last_col, last_row, handshake;
  logic signed [SUM_WIDTH-1:0]   weight_ext, term, acc_sum;

  assign last_col  = (col_reg == LAST_IDX);
  assign last_row  = (row_reg == LAST_IDX);
  assign handshake = sum_valid_reg && sum_ready;

  // Sign-extend before negating so that -(-2^(WEIGHT_WIDTH-1)) is exact.
  assign weight_ext = {{(SUM_WIDTH-WEIGHT_WIDTH){weight[WEIGHT_WIDTH-1]}}, weight};

  // The diagonal is forced to zero regardless of what the memory holds, so a
  // neuron never couples to itself.
  always_comb begin
    term = '0;
    if (col_reg != row_reg) begin
      term = snap_reg[col_reg] ? weight_ext : -weight_ext;
    end
  end

  assign acc_sum = acc_reg + term;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (last_col) state_next = EMIT;
      EMIT:    if (handshake) state_next = last_row ? DONE : ACCUM;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: scan counters, accumulator and the presented result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_reg      <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      acc_reg       <= '0;
      sum_valid_reg <= 1'b0;
      sum_row_reg   <= '0;
      sum_data_reg  <= '0;
      sum_sign_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            snap_reg <= neuron_state;
            row_reg  <= '0;
            col_reg  <= '0;
            acc_reg  <= '0;
          end
        end
        ACCUM: begin
          acc_reg <= acc_sum;
          if (last_col) begin
            // Column address stays on the last column while the row waits in EMIT.
            sum_data_reg  <= acc_sum;
            sum_sign_reg  <= ~acc_sum[SUM_WIDTH-1];
            sum_row_reg   <= row_reg;
            sum_valid_reg <= 1'b1;
          end else begin
            col_reg <= col_reg + 1'b1;
          end
        end
        EMIT: begin
          if (handshake) begin
            sum_valid_reg <= 1'b0;
            if (!last_row) begin
              row_reg <= row_reg + 1'b1;
              col_reg <= '0;
              acc_reg <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign addr_row  = row_reg;
  assign addr_col  = col_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign sum_valid = sum_valid_reg;
  assign sum_row   = sum_row_reg;
  assign sum_data  = sum_data_reg;
  assign sum_sign  = sum_sign_reg;

endmodule

// File: tb/tb_synapse_row_accumulator.sv
// tb_synapse_row_accumulator
//
// Drives synapse_row_accumulator from a behavioural weight memory and checks
// every presented row result against a reference computed directly from the
// matrix and the phase snapshot. Directed scans pin the reference with
// hand-computed values; randomized scans add backpressure, mid-scan start
// pulses, neuron_state changes and a mid-scan reset.
module tb_synapse_row_accumulator;
  localparam int N = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [N-1:0]      neuron_state = '0;
  logic [3:0]        addr_row, addr_col;
  logic signed [4:0] weight;
  logic              busy, sum_valid;
  logic              sum_ready = 1'b1;
  logic [3:0]        sum_row;
  logic signed [8:0] sum_data;
  logic              sum_sign, done;

  always #5 clk = ~clk;

  synapse_row_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .neuron_state(neuron_state),
    .addr_row(addr_row), .addr_col(addr_col), .weight(weight),
    .busy(busy), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .sum_row(sum_row), .sum_data(sum_data), .sum_sign(sum_sign), .done(done)
  );

  // Weight memory with a combinational read port.
  logic signed [4:0] wmem [0:15][0:15];
  assign weight = wmem[addr_row][addr_col];

  typedef struct {int row; int data;} exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int got_data [N];
  int got_sign [N];
  int accepted = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: coupling sum of every row, diagonal excluded, s_j = +/-1.
  task automatic push_model(input logic [N-1:0] st);
    for (int i = 0; i < N; i++) begin
      exp_t e;
      int s = 0;
      for (int j = 0; j < N; j++) begin
        if (j != i) s += st[j] ? int'(wmem[i][j]) : -int'(wmem[i][j]);
      end
      e.row = i;
      e.data = s;
      exp_q.push_back(e);
    end
  endtask

  // Compare process: every cycle a result is presented it must equal the
  // oldest outstanding reference row; it is retired on the handshake.
  always @(negedge clk) begin
    if (rst_n && sum_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sum", 1, 0);
      end else begin
        chk("sum_row", int'(sum_row), exp_q[0].row);
        chk("sum_data", int'(sum_data), exp_q[0].data);
        chk("sum_sign", int'(sum_sign), int'(exp_q[0].data >= 0));
        $display("row %0d data %0d sign %0d ready %0d", sum_row, sum_data, sum_sign, sum_ready);
        if (sum_ready) begin
          got_data[exp_q[0].row] = int'(sum_data);
          got_sign[exp_q[0].row] = int'(sum_sign);
          accepted++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr_row"}, int'(addr_row), 0);
    chk({tag, "_addr_col"}, int'(addr_col), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_sum_valid"}, int'(sum_valid), 0);
    chk({tag, "_sum_row"}, int'(sum_row), 0);
    chk({tag, "_sum_data"}, int'(sum_data), 0);
    chk({tag, "_sum_sign"}, int'(sum_sign), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // mode: 0 ready high, 1 random ready, 2 five-cycle stall on row 3.
  // exp_done: cycle (counted from T+1 = 1) at which done must appear, 0 = skip.
  task automatic run_scan(input logic [N-1:0] st, input int mode, input bit noise,
                          input int rst_at_row, input int exp_done);
    int n, first_n, done_n, stall_left, seen;
    bit aborted;
    first_n = -1; done_n = -1; stall_left = 5; aborted = 0; accepted = 0;
    @(posedge clk); #1;
    start = 1'b1;
    neuron_state = st;
    push_model(st);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_T1", int'(busy), 1);
    chk("addr_row_T1", int'(addr_row), 0);
    chk("addr_col_T1", int'(addr_col), 0);
    n = 1;
    while (n < 3000) begin
      if (mode == 0) sum_ready = 1'b1;
      else if (mode == 1) sum_ready = 1'($urandom_range(0, 1));
      else if (sum_valid && sum_row == 4'd3 && stall_left > 0) begin
        sum_ready = 1'b0;
        stall_left--;
      end else sum_ready = 1'b1;
      if (noise) begin
        neuron_state = N'($urandom);
        start = busy && ($urandom_range(0, 7) == 0);
      end
      if (rst_at_row >= 0 && int'(addr_row) == rst_at_row && addr_col == 4'd5) begin
        rst_n = 1'b0;
        exp_q.delete();
        aborted = 1;
      end
      @(negedge clk);
      if (sum_valid && first_n < 0) first_n = n;
      if (done) begin
        done_n = n;
        break;
      end
      if (aborted) break;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    sum_ready = 1'b1;
    if (aborted) begin
      @(posedge clk); #1;
      chk_reset_outputs("midscan_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (30) begin
        @(negedge clk);
        if (done || busy) seen = 1;
      end
      chk("no_done_after_reset", seen, 0);
      chk("queue_after_reset", exp_q.size(), 0);
    end else begin
      chk("scan_completed", int'(done_n > 0), 1);
      if (exp_done > 0) begin
        chk("first_valid_cycle", first_n, 16);
        chk("done_cycle", done_n, exp_done);
      end
      chk("rows_accepted", accepted, N);
      chk("queue_empty", exp_q.size(), 0);
      @(posedge clk); #1;
      chk("busy_after_done", int'(busy), 0);
      chk("done_one_cycle", int'(done), 0);
    end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) wmem[i][j] = 5'(v);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) wmem[i][j] = 5'($urandom_range(0, 31));
  endtask

  initial begin
    fill_const(0);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // All +1, all phases +1: each row sums 14 off-diagonal ones.
    fill_const(1);
    run_scan(15'h7FFF, 0, 0, -1, 241);
    for (int r = 0; r < N; r++) begin
      chk("ones_data", got_data[r], 14);
      chk("ones_sign", got_sign[r], 1);
    end

    // All -16, all phases -1: each term is +16, 14 terms give 224.
    fill_const(-16);
    run_scan(15'h0000, 0, 0, -1, 241);
    for (int r = 0; r < N; r++) chk("neg16_data", got_data[r], 224);

    // Only the diagonal is non-zero: the guard must yield zero everywhere.
    fill_const(0);
    for (int i = 0; i < N; i++) wmem[i][i] = 5'sd15;
    run_scan(N'($urandom), 0, 0, -1, 241);
    for (int r = 0; r < N; r++) begin
      chk("diag_data", got_data[r], 0);
      chk("diag_sign", got_sign[r], 1);
    end

    // W[i][j] = j-7, low byte positive, with a five-cycle stall on row 3.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) wmem[i][j] = 5'(j - 7);
    run_scan(15'h00FF, 2, 0, -1, 246);
    chk("mixed_row7", got_data[7], -56);
    chk("mixed_row7_sign", got_sign[7], 0);

    // Random matrices and phases, random backpressure, mid-scan noise.
    repeat (4) begin
      fill_random();
      run_scan(N'($urandom), 1, 1, -1, 0);
    end

    // Reset during row 7, then a full scan from a clean start.
    fill_random();
    run_scan(N'($urandom), 0, 0, 7, 0);
    fill_random();
    run_scan(N'($urandom), 0, 1, -1, 241);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
